load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the data-memory interface: accepts one load/store request at a time from the datapath and drives `MemRead`, `MemWrite`, `addr` and `write_data` into the word-organised data memory. It implements RV32I byte, halfword and word accesses:
- sub-word loads by selecting and extending bytes from the read word;
- sub-word stores by read-modify-write.

It sits between the execute stage and the data memory and replaces direct control of memory strobes by the main decoder.

## Interface
- `ADDR_W`, 9: byte-address width; word index is `addr[ADDR_W-1:2]`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3.
  - Loads: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu.
  - Stores: 0 sb, 1 sh, 2 sw.
- `req_addr` in `ADDR_W`: byte address.
- `req_wdata` in 32: store data, low bits used for sb/sh.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load result, 0 for stores and errors.
- `resp_err` out 1: misaligned or unsupported access, qualified by `resp_valid`.
- `MemRead` out 1: memory read strobe.
- `MemWrite` out 1: memory write strobe.
- `mem_addr` out `ADDR_W`: word-aligned address, `{word index, 2'b00}`.
- `mem_wdata` out 32: word to write.
- `mem_rdata` in 32: memory read data, combinational from `mem_addr` while `MemRead` is high.

## Operation
- States:
  - IDLE
  - LOAD
  - WRITE
  - RMW_RD
  - RMW_WR
  - RESP
- Request capture:
  - A request is accepted on a rising edge where `req_valid && req_ready`.
  - `req_store`, `req_funct3`, `req_addr` and `req_wdata` are latched at acceptance.
- Decode at acceptance, from IDLE:
  - Error → RESP with error flag set. An error is one of:
    - lh/lhu/sh with `addr[0]=1`;
    - lw/sw with `addr[1:0]≠0`;
    - funct3 3, 6 or 7;
    - a store with funct3 4 or 5.
  - Load → LOAD.
  - sw → WRITE.
  - sb/sh → RMW_RD.
- LOAD:
  - `MemRead=1`.
  - Selected lane of `mem_rdata` is captured at the edge:
    - byte `addr[1:0]`: bits [8k+7:8k];
    - half `addr[1]`: bits [16h+15:16h].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw is unmodified.
  - → RESP.
- WRITE:
  - `MemWrite=1`, `mem_wdata = latched wdata`.
  - → RESP.
- RMW_RD:
  - `MemRead=1`.
  - Capture `mem_rdata` merged with the store lane:
    - sb replaces byte `addr[1:0]` with `wdata[7:0]`;
    - sh replaces half `addr[1]` with `wdata[15:0]`.
  - → RMW_WR.
- RMW_WR:
  - `MemWrite=1`, `mem_wdata = merged word`.
  - → RESP.
- RESP:
  - `resp_valid=1` for exactly one cycle, with `resp_rdata`/`resp_err` valid.
  - → IDLE.
- Error requests never assert `MemRead` or `MemWrite`.
- Strobes:
  - `MemRead`/`MemWrite` decode from the state register only, gated by `!reset`.
  - `MemRead` and `MemWrite` are never both high.
- `req_valid` outside IDLE is ignored; there is no queueing.

## Timing
- Acceptance edge is T0.
- Load / sw: strobe during cycle T0→T1; `resp_valid` during T1→T2 (latency 2).
- sb/sh: `MemRead` during T0→T1, `MemWrite` during T1→T2, `resp_valid` during T2→T3 (latency 3).
- Error: `resp_valid` with `resp_err=1` during T0→T1 (latency 1).
- Next request is accepted at the earliest on the edge ending the RESP cycle plus one, because `req_ready` returns high in IDLE.
- Reset values:
  - state IDLE, so `req_ready=1`;
  - `resp_valid=0`, `resp_rdata=0`, `resp_err=0`;
  - `MemRead=0`, `MemWrite=0`;
  - `mem_addr=0`, `mem_wdata=0`.
- Reset mid-operation:
  - Strobes are forced 0 in any cycle `reset` is high.
  - The operation is dropped with no response.
  - A reset during RMW_WR leaves memory unmodified.
- `mem_addr`/`mem_wdata` hold their latched values from acceptance until the next acceptance.

## Structure
- Shared package `lsu_pkg`:
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`;
  - state encoding localparams.
- One sub-module `lsu_align`, combinational:
  - load lane select + extension (`rdata`, `addr[1:0]`, `funct3` → 32-bit result);
  - store merge (`old word`, `wdata`, `addr[1:0]`, `funct3` → merged word).
- The FSM, latches and strobe decode stay in `load_store_unit`.

## Test plan
Memory word at 0x010 preloaded to 0x876543A1.
- lw @0x010 → `MemRead` high the cycle after acceptance with `mem_addr`=0x010; next cycle `resp_valid=1`, `resp_rdata`=0x876543A1, `resp_err=0`.
- Sub-word loads:
  - lb @0x010 → 0xFFFFFFA1;
  - lbu @0x013 → 0x00000087;
  - lh @0x012 → 0xFFFF8765;
  - lhu @0x010 → 0x000043A1;
  - each with latency 2.
- sb @0x011 with `req_wdata`=0x123456FF:
  - `MemRead` at T0→T1, then `MemWrite` with `mem_wdata`=0x8765FFA1 at T1→T2, `resp_valid` at T2→T3;
  - follow-up lw @0x010 → 0x8765FFA1.
- Error requests → `resp_valid=1`, `resp_err=1`, `resp_rdata=0` one cycle after acceptance; `MemRead`/`MemWrite` stay 0 throughout. Cases: sh @0x011, lw @0x012, load with funct3=3.
- `reset` pulsed during the RMW_WR cycle of sh @0x010 with data 0xBEEF → `MemWrite` stays 0, no `resp_valid`, `req_ready=1` on the following cycle, lw @0x010 still returns 0x876543A1.
- `req_valid` held high with a second request during a busy sb → second request is not accepted until `req_ready` returns high; exactly one memory write is observed per accepted store.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RV32I funct3 encodings for loads and stores
//   - FSM state encoding
//   - access_err(): decode of misaligned/unsupported requests
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_WRITE  = 3'd2;
    localparam logic [2:0] ST_RMW_RD = 3'd3;
    localparam logic [2:0] ST_RMW_WR = 3'd4;
    localparam logic [2:0] ST_RESP   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LOAD   = ST_LOAD,
        S_WRITE  = ST_WRITE,
        S_RMW_RD = ST_RMW_RD,
        S_RMW_WR = ST_RMW_WR,
        S_RESP   = ST_RESP
    } lsu_state_e;

    // Unsigned variants only exist for loads, so a store with funct3 4/5
    // is treated as unsupported.
    function automatic logic access_err(input logic       store,
                                        input logic [2:0] f3,
                                        input logic [1:0] addr_lo);
        logic err;
        case (f3)
            F3_B:    err = 1'b0;
            F3_H:    err = addr_lo[0];
            F3_W:    err = (addr_lo != 2'b00);
            F3_BU:   err = store;
            F3_HU:   err = store | addr_lo[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake between the execute stage (master) and the
// load/store unit (slave).
//   req_valid/req_ready      : request handshake
//   req_store/funct3/addr/wdata : request payload, latched at acceptance
//   resp_valid/rdata/err     : one-cycle completion pulse and result
interface lsu_if #(parameter int ADDR_W = 9);

    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane handling for sub-word accesses.
//   rdata     : word read from memory
//   addr_lo   : byte offset within the word
//   funct3    : access size / signedness
//   wdata     : low store data (sb uses [7:0], sh uses [15:0])
//   load_data : selected lane, sign- or zero-extended (lw passes through)
//   merged    : rdata with the store lane replaced, for read-modify-write
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = rdata;
        endcase

        merged = rdata;
        if (funct3 == F3_B) begin
            merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
        end else if (funct3 == F3_H) begin
            merged[{addr_lo[1], 4'b0000} +: 16] = wdata;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the word-organised data memory.
// Handles one RV32I load/store at a time; sub-word stores use
// read-modify-write.
//   clk, reset : clock, synchronous active-high reset
//   bus        : request/response handshake (lsu_if slave)
//   MemRead    : memory read strobe
//   MemWrite   : memory write strobe
//   mem_addr   : word-aligned byte address
//   mem_wdata  : word to write
//   mem_rdata  : combinational read data for mem_addr
//
// state  | meaning
// -------+--------------------------------------------------
// IDLE   | ready for a request
// LOAD   | MemRead, capture extended load lane
// WRITE  | MemWrite of full word (sw)
// RMW_RD | MemRead, capture word merged with store lane
// RMW_WR | MemWrite of merged word
// RESP   | one-cycle response pulse
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    lsu_if.slave              bus,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic              store_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       data_q, data_d;
    logic              err_q, err_d;

    logic              accept;
    logic [31:0]       load_data;
    logic [31:0]       merged;

    assign accept = bus.req_valid && (state_q == S_IDLE);

    lsu_align u_align (
        .rdata     (mem_rdata),
        .addr_lo   (addr_q[1:0]),
        .funct3    (f3_q),
        .wdata     (wdata_q[15:0]),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            store_q <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
            if (accept) begin
                store_q <= bus.req_store;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    err_d  = access_err(bus.req_store, bus.req_funct3, bus.req_addr[1:0]);
                    data_d = 32'd0;
                    if (err_d) begin
                        state_d = S_RESP;
                    end else if (!bus.req_store) begin
                        state_d = S_LOAD;
                    end else if (bus.req_funct3 == F3_W) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_LOAD: begin
                data_d  = load_data;
                state_d = S_RESP;
            end
            S_WRITE:  state_d = S_RESP;
            S_RMW_RD: begin
                data_d  = merged;
                state_d = S_RMW_WR;
            end
            S_RMW_WR: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobes come straight from the state register; gating with reset keeps
    // a reset landing in RMW_WR from corrupting memory.
    assign MemRead  = !reset && ((state_q == S_LOAD)  || (state_q == S_RMW_RD));
    assign MemWrite = !reset && ((state_q == S_WRITE) || (state_q == S_RMW_WR));

    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata = (state_q == S_RMW_WR) ? data_q : wdata_q;

    // data_q carries the merged word for sub-word stores, so the result is
    // masked for stores.
    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_err   = (state_q == S_RESP) && err_q;
    assign bus.resp_rdata = ((state_q == S_RESP) && !store_q) ? data_q : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:127];
    int          write_count;
    int          checks;
    int          errors;

    lsu_if #(.ADDR_W(9)) bus_if ();

    load_store_unit #(.ADDR_W(9)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[8:2]];

    always @(posedge clk) begin
        if (MemWrite) begin
            mem[mem_addr[8:2]] <= mem_wdata;
            write_count = write_count + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Drives one request at a negedge, releases it after the acceptance edge,
    // and returns at the negedge inside cycle T0->T1.
    task automatic issue(input logic st, input logic [2:0] f3,
                         input logic [8:0] a, input logic [31:0] wd);
        @(negedge clk);
        bus_if.req_store  = st;
        bus_if.req_funct3 = f3;
        bus_if.req_addr   = a;
        bus_if.req_wdata  = wd;
        bus_if.req_valid  = 1'b1;
        @(posedge clk);
        #1 bus_if.req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus_if.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus_if.req_ready); end
        checks++; if (bus_if.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0", bus_if.resp_valid); end
        checks++; if (bus_if.resp_rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata: got %h want 0", bus_if.resp_rdata); end
        checks++; if (bus_if.resp_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus_if.resp_err); end
        checks++; if ({MemRead, MemWrite} !== 2'b00) begin errors++; $display("FAIL rst_strobes: got %b want 00", {MemRead, MemWrite}); end
        checks++; if (mem_addr !== 9'd0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'd0) begin errors++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
        reset = 1'b0;
    endtask

    task automatic test_lw;
        issue(1'b0, 3'd2, 9'h010, 32'd0);
        checks++; if (MemRead !== 1'b1 || MemWrite !== 1'b0) begin errors++; $display("FAIL lw_strobe: got rd=%b wr=%b want rd=1 wr=0", MemRead, MemWrite); end
        checks++; if (mem_addr !== 9'h010) begin errors++; $display("FAIL lw_addr: got %h want 010", mem_addr); end
        checks++; if (bus_if.resp_valid !== 1'b0) begin errors++; $display("FAIL lw_early_resp: got %b want 0", bus_if.resp_valid); end
        @(negedge clk);
        checks++; if (bus_if.resp_valid !== 1'b1) begin errors++; $display("FAIL lw_resp_valid: got %b want 1", bus_if.resp_valid); end
        checks++; if (bus_if.resp_rdata !== 32'h876543A1) begin errors++; $display("FAIL lw_rdata: got %h want 876543a1", bus_if.resp_rdata); end
        checks++; if (bus_if.resp_err !== 1'b0) begin errors++; $display("FAIL lw_err: got %b want 0", bus_if.resp_err); end
        @(negedge clk);
        checks++; if (bus_if.resp_valid !== 1'b0 || bus_if.req_ready !== 1'b1) begin errors++; $display("FAIL lw_after: got valid=%b ready=%b want 0/1", bus_if.resp_valid, bus_if.req_ready); end
    endtask

    task automatic test_subword_loads;
        logic [2:0]  f3v [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        logic [8:0]  av  [4] = '{9'h010, 9'h013, 9'h012, 9'h010};
        logic [31:0] ev  [4] = '{32'hFFFFFFA1, 32'h00000087, 32'hFFFF8765, 32'h000043A1};
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, f3v[i], av[i], 32'd0);
            checks++; if (MemRead !== 1'b1 || bus_if.resp_valid !== 1'b0) begin errors++; $display("FAIL subload%0d_t0: got rd=%b valid=%b want 1/0", i, MemRead, bus_if.resp_valid); end
            @(negedge clk);
            checks++; if (bus_if.resp_valid !== 1'b1 || bus_if.resp_rdata !== ev[i] || bus_if.resp_err !== 1'b0) begin
                errors++; $display("FAIL subload%0d: got valid=%b rdata=%h err=%b want 1/%h/0", i, bus_if.resp_valid, bus_if.resp_rdata, bus_if.resp_err, ev[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sb;
        issue(1'b1, 3'd0, 9'h011, 32'h123456FF);
        checks++; if (MemRead !== 1'b1 || MemWrite !== 1'b0) begin errors++; $display("FAIL sb_t0: got rd=%b wr=%b want 1/0", MemRead, MemWrite); end
        @(negedge clk);
        checks++; if (MemRead !== 1'b0 || MemWrite !== 1'b1) begin errors++; $display("FAIL sb_t1: got rd=%b wr=%b want 0/1", MemRead, MemWrite); end
        checks++; if (mem_wdata !== 32'h8765FFA1) begin errors++; $display("FAIL sb_wdata: got %h want 8765ffa1", mem_wdata); end
        @(negedge clk);
        checks++; if (bus_if.resp_valid !== 1'b1 || bus_if.resp_err !== 1'b0 || bus_if.resp_rdata !== 32'd0) begin
            errors++; $display("FAIL sb_resp: got valid=%b err=%b rdata=%h want 1/0/0", bus_if.resp_valid, bus_if.resp_err, bus_if.resp_rdata);
        end
        @(negedge clk);
        issue(1'b0, 3'd2, 9'h010, 32'd0);
        @(negedge clk);
        checks++; if (bus_if.resp_valid !== 1'b1 || bus_if.resp_rdata !== 32'h8765FFA1) begin errors++; $display("FAIL sb_readback: got valid=%b rdata=%h want 1/8765ffa1", bus_if.resp_valid, bus_if.resp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_errors;
        logic        stv [3] = '{1'b1, 1'b0, 1'b0};
        logic [2:0]  f3v [3] = '{3'd1, 3'd2, 3'd3};
        logic [8:0]  av  [3] = '{9'h011, 9'h012, 9'h010};
        for (int i = 0; i < 3; i++) begin
            issue(stv[i], f3v[i], av[i], 32'hDEADBEEF);
            checks++; if (bus_if.resp_valid !== 1'b1 || bus_if.resp_err !== 1'b1 || bus_if.resp_rdata !== 32'd0) begin
                errors++; $display("FAIL err%0d_resp: got valid=%b err=%b rdata=%h want 1/1/0", i, bus_if.resp_valid, bus_if.resp_err, bus_if.resp_rdata);
            end
            checks++; if ({MemRead, MemWrite} !== 2'b00) begin errors++; $display("FAIL err%0d_strobe_t0: got %b want 00", i, {MemRead, MemWrite}); end
            @(negedge clk);
            checks++; if ({MemRead, MemWrite} !== 2'b00 || bus_if.resp_valid !== 1'b0 || bus_if.req_ready !== 1'b1) begin
                errors++; $display("FAIL err%0d_after: got strobes=%b valid=%b ready=%b want 00/0/1", i, {MemRead, MemWrite}, bus_if.resp_valid, bus_if.req_ready);
            end
        end
    endtask

    task automatic test_reset_rmw;
        int w0;
        mem[4] = 32'h876543A1;
        w0 = write_count;
        issue(1'b1, 3'd1, 9'h010, 32'h0000BEEF);
        checks++; if (MemRead !== 1'b1) begin errors++; $display("FAIL rstrmw_rd: got %b want 1", MemRead); end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks++; if (MemWrite !== 1'b0 || bus_if.resp_valid !== 1'b0) begin errors++; $display("FAIL rstrmw_wr: got wr=%b valid=%b want 0/0", MemWrite, bus_if.resp_valid); end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (bus_if.req_ready !== 1'b1 || bus_if.resp_valid !== 1'b0 || MemWrite !== 1'b0) begin
            errors++; $display("FAIL rstrmw_after: got ready=%b valid=%b wr=%b want 1/0/0", bus_if.req_ready, bus_if.resp_valid, MemWrite);
        end
        checks++; if (write_count != w0) begin errors++; $display("FAIL rstrmw_writes: got %0d want %0d", write_count, w0); end
        issue(1'b0, 3'd2, 9'h010, 32'd0);
        @(negedge clk);
        checks++; if (bus_if.resp_valid !== 1'b1 || bus_if.resp_rdata !== 32'h876543A1) begin errors++; $display("FAIL rstrmw_readback: got valid=%b rdata=%h want 1/876543a1", bus_if.resp_valid, bus_if.resp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int w0;
        logic [3:0] ready_seen;
        w0 = write_count;
        @(negedge clk);
        bus_if.req_store  = 1'b1;
        bus_if.req_funct3 = 3'd0;
        bus_if.req_addr   = 9'h012;
        bus_if.req_wdata  = 32'h000000AA;
        bus_if.req_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus_if.req_store  = 1'b0;
        bus_if.req_funct3 = 3'd2;
        bus_if.req_addr   = 9'h010;
        bus_if.req_wdata  = 32'd0;
        // T0-T1 RMW_RD, T1-T2 RMW_WR, T2-T3 RESP, T3-T4 IDLE
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ready_seen[c] = bus_if.req_ready;
        end
        checks++; if (ready_seen !== 4'b1000) begin errors++; $display("FAIL b2b_ready: got %b want 1000", ready_seen); end
        @(posedge clk);
        #1 bus_if.req_valid = 1'b0;
        @(negedge clk);
        checks++; if (MemRead !== 1'b1 || mem_addr !== 9'h010) begin errors++; $display("FAIL b2b_second_rd: got rd=%b addr=%h want 1/010", MemRead, mem_addr); end
        @(negedge clk);
        checks++; if (bus_if.resp_valid !== 1'b1 || bus_if.resp_rdata !== 32'h87AA43A1) begin errors++; $display("FAIL b2b_rdata: got valid=%b rdata=%h want 1/87aa43a1", bus_if.resp_valid, bus_if.resp_rdata); end
        checks++; if (write_count - w0 != 1) begin errors++; $display("FAIL b2b_writes: got %0d want 1", write_count - w0); end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        write_count = 0;
        for (int i = 0; i < 128; i++) mem[i] = 32'd0;
        mem[4] = 32'h876543A1;
        reset = 1'b1;
        bus_if.req_valid  = 1'b0;
        bus_if.req_store  = 1'b0;
        bus_if.req_funct3 = 3'd0;
        bus_if.req_addr   = 9'd0;
        bus_if.req_wdata  = 32'd0;

        test_reset;
        test_lw;
        test_subword_loads;
        test_sb;
        mem[4] = 32'h876543A1;
        test_errors;
        test_reset_rmw;
        test_back_to_back;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
